// File: rtl/processor_pkg.sv
// processor_pkg
//   Shared types and constants for the processor front end.
//   - fetch_state_e : fetch FSM encoding (WAIT = address driven and timer
//                     running, VALID = instruction held for decode)
//   - RESET_PC      : default first fetch address after reset
//   - EXC_VECTOR    : default overflow-exception handler address
//   - PC_INCR       : sequential fetch stride in bytes
package processor_pkg;

  typedef enum logic {
    FETCH_WAIT  = 1'b0,
    FETCH_VALID = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'hF000_0000;
  localparam logic [31:0] PC_INCR    = 32'd4;

endpackage : processor_pkg

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer
//   Down-counter that measures the instruction-memory access time.
//   Ports:
//     clk   in   clock, rising edge
//     rst_n in   asynchronous active-low reset (count returns to LOAD_VALUE)
//     load  in   reload the count with LOAD_VALUE (wins over dec)
//     dec   in   decrement by one; saturates at zero
//     zero  out  count is zero (memory data may be sampled this edge)
module fetch_wait_timer #(
  parameter int unsigned LOAD_VALUE = 1,
  parameter int unsigned WIDTH      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [WIDTH-1:0] LOAD_CNT = WIDTH'(LOAD_VALUE);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = LOAD_CNT;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= LOAD_CNT;
    end else begin
      count_reg <= count_next;
    end
  end

  assign zero = (count_reg == '0);

endmodule : fetch_wait_timer

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetches one instruction at a time from a fixed-latency instruction
//   memory and holds it for decode until accepted. Redirect and Exception
//   flush any fetch in progress and restart at the new target.
//   Optional feature: define FETCH_PERF_CNT_EN to build the delivered-
//   instruction counter on FetchCount; otherwise FetchCount is tied to 0.
//   Ports:
//     CLK         in   clock, rising edge
//     Reset_L     in   asynchronous active-low reset
//     IMemAddr    out  [31:0] fetch address (the PC)
//     IMemData    in   [31:0] instruction word from memory
//     Instr       out  [31:0] held instruction
//     InstrPC     out  [31:0] address Instr came from
//     InstrValid  out  Instr/InstrPC valid
//     InstrReady  in   decode accepts Instr this cycle
//     Redirect    in   branch/jump redirect request
//     RedirectPC  in   [31:0] redirect target (low two bits ignored)
//     Exception   in   overflow exception, fetch from EXC_VECTOR
//     FetchCount  out  [31:0] number of accepted instructions
module instr_fetch_unit #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] RESET_PC    = processor_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR  = processor_pkg::EXC_VECTOR
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Exception,
  output logic [31:0] FetchCount
);

  import processor_pkg::*;

  localparam int unsigned TIMER_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  instr_pc_reg, instr_pc_next;
  logic         handshake;
  logic         timer_load;
  logic         timer_dec;
  logic         timer_zero;

  // An accepted instruction counts even when a same-edge flush overrides
  // the sequential PC update.
  assign handshake = (state_reg == FETCH_VALID) && InstrReady;
  assign timer_dec = (state_reg == FETCH_WAIT);

  fetch_wait_timer #(
    .LOAD_VALUE (WAIT_CYCLES),
    .WIDTH      (TIMER_W)
  ) u_wait_timer (
    .clk   (CLK),
    .rst_n (Reset_L),
    .load  (timer_load),
    .dec   (timer_dec),
    .zero  (timer_zero)
  );

  // Priority: Exception > Redirect > normal FSM progress (capture/handshake).
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    timer_load    = 1'b0;

    if (Exception) begin
      pc_next    = EXC_VECTOR;
      state_next = FETCH_WAIT;
      timer_load = 1'b1;
    end else if (Redirect) begin
      pc_next    = {RedirectPC[31:2], 2'b00};
      state_next = FETCH_WAIT;
      timer_load = 1'b1;
    end else begin
      case (state_reg)
        FETCH_WAIT: begin
          if (timer_zero) begin
            instr_next    = IMemData;
            instr_pc_next = pc_reg;
            state_next    = FETCH_VALID;
          end
        end
        FETCH_VALID: begin
          if (InstrReady) begin
            pc_next    = pc_reg + PC_INCR;  // wraps naturally at 2^32
            state_next = FETCH_WAIT;
            timer_load = 1'b1;
          end
        end
        default: begin
          state_next = FETCH_WAIT;
          timer_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_reg    <= FETCH_WAIT;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_reg;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      fetch_count_reg <= '0;
    end else if (handshake) begin
      fetch_count_reg <= fetch_count_reg + 32'd1;
    end
  end

  assign FetchCount = fetch_count_reg;
`else
  assign FetchCount = '0;
`endif

  assign IMemAddr   = pc_reg;
  assign Instr      = instr_reg;
  assign InstrPC    = instr_pc_reg;
  assign InstrValid = (state_reg == FETCH_VALID);

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit (WAIT_CYCLES=1) against a small
//   test-program instruction memory image. Expected FetchCount follows
//   FETCH_PERF_CNT_EN.
module tb_instr_fetch_unit;

  localparam logic [31:0] EXC = 32'hF000_0000;

  logic        CLK;
  logic        Reset_L;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Exception;
  logic [31:0] FetchCount;

  int checks;
  int errors;
  int exp_hs;

  instr_fetch_unit #(
    .WAIT_CYCLES (1),
    .RESET_PC    (32'h0000_0000),
    .EXC_VECTOR  (EXC)
  ) dut (
    .CLK        (CLK),
    .Reset_L    (Reset_L),
    .IMemAddr   (IMemAddr),
    .IMemData   (IMemData),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Exception  (Exception),
    .FetchCount (FetchCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Test-program image; unlisted addresses return a pattern derived from
  // the address so any wrong-address capture is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h3408_0032;
      32'h0000_0004: mem_word = 32'hac08_0000;
      32'h0000_0008: mem_word = 32'h3408_0028;
      32'h0000_000C: mem_word = 32'hac08_0004;
      32'h0000_0010: mem_word = 32'h2009_fffe;
      32'h0000_002C: mem_word = 32'h8c09_0004;
      32'h0000_0180: mem_word = 32'h3409_feed;
      32'hF000_0000: mem_word = 32'h8c08_0000;
      default:       mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always_comb IMemData = mem_word(IMemAddr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle to a sampling point away from it.
  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic deliver(input logic [31:0] pc);
    for (int n = 0; n < 16 && !InstrValid; n++) tick();
    check_eq("valid_wait", {31'd0, InstrValid}, 32'd1);
    check_eq("instr_pc", InstrPC, pc);
    check_eq("instr", Instr, mem_word(pc));
    $display("deliver pc=%08h instr=%08h", InstrPC, Instr);
  endtask

  function automatic logic [31:0] exp_count(input int hs);
`ifdef FETCH_PERF_CNT_EN
    exp_count = 32'(hs);
`else
    exp_count = 32'd0;
`endif
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    exp_hs     = 0;
    Reset_L    = 1'b0;
    InstrReady = 1'b0;
    Redirect   = 1'b0;
    RedirectPC = '0;
    Exception  = 1'b0;

    repeat (2) tick();
    check_eq("rst_addr", IMemAddr, 32'h0);
    check_eq("rst_valid", {31'd0, InstrValid}, 32'd0);
    check_eq("rst_instr", Instr, 32'h0);
    check_eq("rst_ipc", InstrPC, 32'h0);
    check_eq("rst_fcnt", FetchCount, 32'h0);

    // First fetch: valid two edges after release.
    InstrReady = 1'b1;
    Reset_L    = 1'b1;
    check_eq("addr0", IMemAddr, 32'h0);
    tick();
    check_eq("lat1_valid", {31'd0, InstrValid}, 32'd0);
    tick();
    check_eq("lat2_valid", {31'd0, InstrValid}, 32'd1);
    deliver(32'h0);
    tick(); exp_hs++;
    check_eq("hs_clr_valid", {31'd0, InstrValid}, 32'd0);
    check_eq("hs_addr4", IMemAddr, 32'h4);
    deliver(32'h4);

    // Stall at 0x8 for five cycles.
    tick(); exp_hs++;
    InstrReady = 1'b0;
    deliver(32'h8);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_instr", Instr, 32'h3408_0028);
      check_eq("stall_addr", IMemAddr, 32'h8);
      check_eq("stall_valid", {31'd0, InstrValid}, 32'd1);
    end
    InstrReady = 1'b1;
    tick(); exp_hs++;
    check_eq("addr_c", IMemAddr, 32'hC);
    deliver(32'hC);

    // Redirect during WAIT (fetch of 0x10 in flight).
    tick(); exp_hs++;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0181;
    tick();
    Redirect = 1'b0;
    check_eq("redir_addr", IMemAddr, 32'h180);
    check_eq("redir_valid", {31'd0, InstrValid}, 32'd0);
    tick();
    check_eq("redir_lat", {31'd0, InstrValid}, 32'd0);
    deliver(32'h180);

    // Exception + Redirect + handshake on the same edge.
    Exception  = 1'b1;
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_0500;
    tick(); exp_hs++;
    Exception = 1'b0;
    Redirect  = 1'b0;
    check_eq("exc_addr", IMemAddr, EXC);
    check_eq("exc_valid", {31'd0, InstrValid}, 32'd0);
    deliver(EXC);

    // Stream to 21 accepted instructions.
    for (int i = 1; i <= 15; i++) begin
      tick(); exp_hs++;
      deliver(EXC + 32'(4 * i));
    end
    tick(); exp_hs++;
    check_eq("fcnt_21", FetchCount, exp_count(exp_hs));

    // PC wrap at the top of the address space.
    InstrReady = 1'b0;
    Redirect   = 1'b1;
    RedirectPC = 32'hFFFF_FFFF;
    tick();
    Redirect = 1'b0;
    check_eq("top_addr", IMemAddr, 32'hFFFF_FFFC);
    deliver(32'hFFFF_FFFC);
    InstrReady = 1'b1;
    tick(); exp_hs++;
    check_eq("wrap_addr", IMemAddr, 32'h0);

    // Redirect while VALID, then asynchronous reset while VALID at 0x2C.
    InstrReady = 1'b0;
    deliver(32'h0);
    Redirect   = 1'b1;
    RedirectPC = 32'h0000_002C;
    tick();
    Redirect = 1'b0;
    check_eq("vredir_valid", {31'd0, InstrValid}, 32'd0);
    deliver(32'h2C);
    check_eq("fcnt_pre_rst", FetchCount, exp_count(exp_hs));
    #1 Reset_L = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, InstrValid}, 32'd0);
    check_eq("arst_addr", IMemAddr, 32'h0);
    check_eq("arst_instr", Instr, 32'h0);
    check_eq("arst_ipc", InstrPC, 32'h0);
    check_eq("arst_fcnt", FetchCount, 32'h0);
    #1 Reset_L = 1'b1;
    InstrReady = 1'b1;
    tick();
    check_eq("rel_lat1", {31'd0, InstrValid}, 32'd0);
    tick();
    check_eq("rel_lat2", {31'd0, InstrValid}, 32'd1);
    deliver(32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_instr_fetch_unit
